// File: rtl/fetch_pkg.sv
// Shared CPU pipeline constants: inter-stage bus widths, reset PC and bus field positions.
package fetch_pkg;
  localparam int IF_ID_W = 64;
  localparam int JBR_W   = 33;
  localparam int EXC_W   = 33;

  localparam logic [31:0] STARTADDR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;

  // {taken/valid, target[31:0]} layout shared by jbr_bus and exc_bus
  localparam int BUS_TAKEN   = 32;
  localparam int BUS_TGT_MSB = 31;
  localparam int BUS_TGT_LSB = 0;
endpackage

// File: rtl/fetch_redirect_buf.sv
// One-entry redirect buffer and next-PC priority mux (exception > branch > pending > pc+4).
module fetch_redirect_buf
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             next_fetch,
  input  logic [JBR_W-1:0] jbr_bus,
  input  logic [EXC_W-1:0] exc_bus,
  input  logic [31:0]      pc,
  output logic [31:0]      next_pc
);
  logic        exc_valid, jbr_taken;
  logic [31:0] exc_pc, jbr_target;
  logic        redir_pend_q, redir_pend_d;
  logic        redir_exc_q, redir_exc_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  assign exc_valid  = exc_bus[BUS_TAKEN];
  assign exc_pc     = exc_bus[BUS_TGT_MSB:BUS_TGT_LSB];
  assign jbr_taken  = jbr_bus[BUS_TAKEN];
  assign jbr_target = jbr_bus[BUS_TGT_MSB:BUS_TGT_LSB];

  // redir_exc_q remembers that the pending entry is an exception, so a later branch cannot replace it
  always_comb begin
    redir_pend_d = redir_pend_q;
    redir_exc_d  = redir_exc_q;
    redir_pc_d   = redir_pc_q;
    if (next_fetch) begin
      redir_pend_d = 1'b0;
      redir_exc_d  = 1'b0;
    end else if (exc_valid) begin
      redir_pend_d = 1'b1;
      redir_exc_d  = 1'b1;
      redir_pc_d   = exc_pc;
    end else if (jbr_taken && !(redir_pend_q && redir_exc_q)) begin
      redir_pend_d = 1'b1;
      redir_exc_d  = 1'b0;
      redir_pc_d   = jbr_target;
    end
  end

  always_comb begin
    next_pc = pc + PC_STEP;
    if (exc_valid)         next_pc = exc_pc;
    else if (jbr_taken)    next_pc = jbr_target;
    else if (redir_pend_q) next_pc = redir_pc_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redir_pend_q <= 1'b0;
      redir_exc_q  <= 1'b0;
      redir_pc_q   <= 32'h0;
    end else begin
      redir_pend_q <= redir_pend_d;
      redir_exc_q  <= redir_exc_d;
      redir_pc_q   <= redir_pc_d;
    end
  end
endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, counts ROM latency and presents {pc, inst} to decode.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] STARTADDR = STARTADDR_DEF,
  parameter int          ROM_LAT   = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               IF_valid,
  input  logic               next_fetch,
  input  logic [31:0]        inst,
  input  logic [JBR_W-1:0]   jbr_bus,
  input  logic [EXC_W-1:0]   exc_bus,
  output logic [31:0]        inst_addr,
  output logic               IF_over,
  output logic [IF_ID_W-1:0] IF_ID_bus,
  output logic [31:0]        IF_pc,
  output logic [31:0]        IF_inst
);
  localparam logic [0:0] S_WAIT   = 1'b0;
  localparam logic [0:0] S_DONE   = 1'b1;
  localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

  logic [0:0]  state_q, state_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] next_pc;

  fetch_redirect_buf u_rbuf (
    .clk        (clk),
    .resetn     (resetn),
    .next_fetch (next_fetch),
    .jbr_bus    (jbr_bus),
    .exc_bus    (exc_bus),
    .pc         (pc_q),
    .next_pc    (next_pc)
  );

  // next_fetch wins in either state, restarting the latency count on the new PC
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    pc_d      = pc_q;
    if (next_fetch) begin
      pc_d      = next_pc;
      lat_cnt_d = 2'd0;
      state_d   = S_WAIT;
    end else if (state_q == S_WAIT && IF_valid) begin
      lat_cnt_d = lat_cnt_q + 2'd1;
      if (lat_cnt_q == LAT_LAST) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_WAIT;
      lat_cnt_q <= 2'd0;
      pc_q      <= STARTADDR;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      pc_q      <= pc_d;
    end
  end

  assign IF_over   = (state_q == S_DONE);
  assign inst_addr = pc_q;
  assign IF_pc     = pc_q;
  assign IF_inst   = inst;
  assign IF_ID_bus = {pc_q, inst};
endmodule

// File: tb/tb_fetch.sv
// Randomized and directed bench for fetch: three instances (ROM_LAT 1/3/2) against a behavioural model.
module tb_fetch;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        IF_valid = 1'b0;
  logic        nf[3];
  logic [31:0] inst = 32'h0;
  logic [32:0] jbr_bus = 33'h0;
  logic [32:0] exc_bus = 33'h0;
  logic [31:0] ia[3], ipc[3], iin[3];
  logic        ov[3];
  logic [63:0] idb[3];

  int unsigned total = 0;
  int unsigned bad = 0;

  always #5 clk = ~clk;

  fetch #(.STARTADDR(32'h0000_0000), .ROM_LAT(1)) u1 (
    .clk(clk), .resetn(resetn), .IF_valid(IF_valid), .next_fetch(nf[0]), .inst(inst),
    .jbr_bus(jbr_bus), .exc_bus(exc_bus), .inst_addr(ia[0]), .IF_over(ov[0]),
    .IF_ID_bus(idb[0]), .IF_pc(ipc[0]), .IF_inst(iin[0]));
  fetch #(.STARTADDR(32'h0000_0000), .ROM_LAT(3)) u3 (
    .clk(clk), .resetn(resetn), .IF_valid(IF_valid), .next_fetch(nf[1]), .inst(inst),
    .jbr_bus(jbr_bus), .exc_bus(exc_bus), .inst_addr(ia[1]), .IF_over(ov[1]),
    .IF_ID_bus(idb[1]), .IF_pc(ipc[1]), .IF_inst(iin[1]));
  fetch #(.STARTADDR(32'hFFFF_FFFC), .ROM_LAT(2)) uw (
    .clk(clk), .resetn(resetn), .IF_valid(IF_valid), .next_fetch(nf[2]), .inst(inst),
    .jbr_bus(jbr_bus), .exc_bus(exc_bus), .inst_addr(ia[2]), .IF_over(ov[2]),
    .IF_ID_bus(idb[2]), .IF_pc(ipc[2]), .IF_inst(iin[2]));

  // Behavioural model: PC, valid cycles spent on the current fetch, pending redirect
  logic [31:0] m_pc[3];
  int          m_wait[3];
  bit          m_pend[3], m_pexc[3];
  logic [31:0] m_rpc[3];

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 2;
  endfunction

  function automatic logic [31:0] start_of(int k);
    return (k == 2) ? 32'hFFFF_FFFC : 32'h0;
  endfunction

  function automatic bit m_over(int k);
    return m_wait[k] >= lat_of(k);
  endfunction

  task automatic check(string name, int k, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%h expected=%h", name, k, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pc[k] = start_of(k); m_wait[k] = 0; m_pend[k] = 0; m_pexc[k] = 0; m_rpc[k] = 32'h0;
    end
  endtask

  task automatic model_edge(int k);
    if (nf[k]) begin
      if (exc_bus[32])      m_pc[k] = exc_bus[31:0];
      else if (jbr_bus[32]) m_pc[k] = jbr_bus[31:0];
      else if (m_pend[k])   m_pc[k] = m_rpc[k];
      else                  m_pc[k] = m_pc[k] + 32'd4;
      m_pend[k] = 0; m_pexc[k] = 0; m_wait[k] = 0;
    end else begin
      if (IF_valid && m_wait[k] < lat_of(k)) m_wait[k]++;
      if (exc_bus[32]) begin
        m_pend[k] = 1; m_pexc[k] = 1; m_rpc[k] = exc_bus[31:0];
      end else if (jbr_bus[32] && !(m_pend[k] && m_pexc[k])) begin
        m_pend[k] = 1; m_pexc[k] = 0; m_rpc[k] = jbr_bus[31:0];
      end
    end
  endtask

  // One clock: model advances on the rising edge, outputs compared on the falling edge
  task automatic step();
    @(posedge clk);
    if (resetn) for (int k = 0; k < 3; k++) model_edge(k);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("inst_addr", k, ia[k], m_pc[k]);
      check("IF_pc", k, ipc[k], m_pc[k]);
      check("IF_over", k, ov[k], m_over(k));
      if (m_over(k)) begin
        check("IF_ID_bus", k, idb[k], {m_pc[k], inst});
        check("IF_inst", k, iin[k], inst);
      end
    end
  endtask

  task automatic wait_over(int k, int lim, output int n);
    n = 0;
    while (ov[k] !== 1'b1 && n < lim) begin
      step();
      n++;
    end
    check("wait_bound", k, ov[k], 1);
  endtask

  task automatic fetch_one(int k);
    nf[k] = 1'b1;
    step();
    nf[k] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] seen0[$];
    logic [31:0] seenw[$];
    int n;
    for (int k = 0; k < 3; k++) nf[k] = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_addr", 0, ia[0], 32'h0);
    check("rst_over", 0, ov[0], 0);
    check("rst_addr", 1, ia[1], 32'h0);
    check("rst_addr", 2, ia[2], 32'hFFFF_FFFC);

    // ROM_LAT=1 stream with next_fetch tied to IF_over; wrap on the STARTADDR=FFFF_FFFC instance
    resetn = 1'b1;
    IF_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (ov[0]) seen0.push_back(ia[0]);
      if (ov[2]) seenw.push_back(ia[2]);
      nf[0] = ov[0];
      nf[2] = ov[2];
      step();
      if (i == 0) check("first_over", 0, ov[0], 1);
    end
    nf[0] = 1'b0; nf[2] = 1'b0;
    check("seq_len", 0, (seen0.size() >= 4), 1);
    if (seen0.size() >= 4) begin
      check("seq0", 0, seen0[0], 32'h0);
      check("seq1", 0, seen0[1], 32'h4);
      check("seq2", 0, seen0[2], 32'h8);
      check("seq3", 0, seen0[3], 32'hC);
    end
    check("wrap_len", 2, (seenw.size() >= 2), 1);
    if (seenw.size() >= 2) begin
      check("wrap0", 2, seenw[0], 32'hFFFF_FFFC);
      check("wrap1", 2, seenw[1], 32'h0);
    end

    // ROM_LAT=3 latency and stall extension
    wait_over(1, 10, n);
    fetch_one(1);
    wait_over(1, 10, n);
    check("lat3", 1, n, 3);
    fetch_one(1);
    step();
    IF_valid = 1'b0;
    step();
    step();
    IF_valid = 1'b1;
    wait_over(1, 10, n);
    check("lat3_stall", 1, n + 3, 5);

    // branch coincident with next_fetch at pc=0x20
    wait_over(0, 10, n);
    jbr_bus = {1'b1, 32'h20};
    fetch_one(0);
    jbr_bus = 33'h0;
    check("jbr_to_20", 0, ia[0], 32'h20);
    wait_over(0, 10, n);
    jbr_bus = {1'b1, 32'h100};
    fetch_one(0);
    jbr_bus = 33'h0;
    check("jbr_coinc", 0, ia[0], 32'h100);

    // branch while IF_over=0 is buffered until next_fetch
    jbr_bus = {1'b1, 32'h200};
    step();
    jbr_bus = 33'h0;
    wait_over(0, 10, n);
    fetch_one(0);
    check("jbr_buffered", 0, ia[0], 32'h200);
    check("pend_cleared", 0, u1.u_rbuf.redir_pend_q, 0);

    // exception beats a same-cycle branch, and a later branch cannot displace it
    exc_bus = {1'b1, 32'h380};
    jbr_bus = {1'b1, 32'h400};
    step();
    exc_bus = 33'h0; jbr_bus = 33'h0;
    wait_over(0, 10, n);
    fetch_one(0);
    check("exc_prio", 0, ia[0], 32'h380);
    exc_bus = {1'b1, 32'h180};
    step();
    exc_bus = 33'h0;
    jbr_bus = {1'b1, 32'h600};
    step();
    jbr_bus = 33'h0;
    fetch_one(0);
    check("exc_held", 0, ia[0], 32'h180);

    // async reset during WAIT with a pending redirect
    wait_over(1, 10, n);
    fetch_one(1);
    jbr_bus = {1'b1, 32'h500};
    step();
    jbr_bus = 33'h0;
    check("pend_set", 1, u3.u_rbuf.redir_pend_q, 1);
    resetn = 1'b0;
    #1;
    check("arst_addr", 1, ia[1], 32'h0);
    check("arst_over", 1, ov[1], 0);
    check("arst_pend", 1, u3.u_rbuf.redir_pend_q, 0);
    check("arst_addr", 2, ia[2], 32'hFFFF_FFFC);
    model_reset();
    step();
    resetn = 1'b1;
    wait_over(1, 10, n);
    check("post_rst_lat", 1, n, 3);
    fetch_one(1);
    check("post_rst_seq", 1, ia[1], 32'h4);

    // randomized traffic, model-checked each cycle
    for (int c = 0; c < 3000; c++) begin
      IF_valid = ($urandom_range(9) < 8);
      inst     = $urandom;
      jbr_bus  = {($urandom_range(7) == 0), $urandom & 32'hFFFF_FFFC};
      exc_bus  = {($urandom_range(19) == 0), $urandom & 32'hFFFF_FFFC};
      for (int k = 0; k < 3; k++) nf[k] = m_over(k) && ($urandom_range(3) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
